// File: rtl/cmp_share_arbiter_if.sv
// Request/result bundle between the compare requesters and the shared
// compare sequencer.
//   req    : request level per requester (bit i = requester i)
//   opa/opb: operand pair of requester i at [i*WIDTH +: WIDTH]
//   done   : one-hot, one-cycle result-valid pulse
//   eq/lt/gt: registered unsigned compare result of the last transaction
//   gnt_id : index of the current or last granted requester
//   busy   : sequencer is not idle
interface cmp_share_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] opa;
    logic [NREQ*WIDTH-1:0] opb;
    logic [NREQ-1:0]       done;
    logic                  eq;
    logic                  lt;
    logic                  gt;
    logic [IDW-1:0]        gnt_id;
    logic                  busy;

    // Requester side
    modport master (
        output req, opa, opb,
        input  done, eq, lt, gt, gnt_id, busy
    );

    // Sequencer side
    modport slave (
        input  req, opa, opb,
        output done, eq, lt, gt, gnt_id, busy
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one unsigned magnitude comparator
// among NREQ requesters. One transaction takes three cycles:
// IDLE (grant + operand latch) -> EVAL (compare, register result + DONE)
// -> RESP (DONE visible, advance pointer).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of cmp_share_arbiter_if (requests in, results out)
module cmp_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    cmp_share_arbiter_if.slave  bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gnt_q, gnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;
    logic               gt_q, gt_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW:0]       idx;
    logic [WIDTH-1:0]   opa_sel;
    logic [WIDTH-1:0]   opb_sel;

    // Rotating priority search: first set request at or above ptr, modulo NREQ.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!found && bus.req[idx[IDW-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx[IDW-1:0];
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        opa_sel = '0;
        opb_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                opa_sel = bus.opa[i*WIDTH +: WIDTH];
                opb_sel = bus.opb[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        done_d  = '0;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    opa_d   = opa_sel;
                    opb_d   = opb_sel;
                    gnt_d   = grant_idx;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                // Latched operands only; live operands are ignored here.
                eq_d    = (opa_q == opb_q);
                lt_d    = (opa_q <  opb_q);
                gt_d    = (opa_q >  opb_q);
                done_d  = NREQ'(1) << gnt_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                // Served requester drops to lowest priority.
                if (gnt_q == IDW'(NREQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gnt_q + IDW'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            done_q  <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.done   = done_q;
    assign bus.eq     = eq_q;
    assign bus.lt     = lt_q;
    assign bus.gt     = gt_q;
    assign bus.gnt_id = gnt_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed vector table,
// hand-written corner sequences, exhaustive compare and randomized traffic
// against a transaction-level round-robin reference model.
module tb_cmp_share_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned IDW   = 2;

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] opa;
        logic [NREQ*WIDTH-1:0] opb;
        int                    g;
        logic                  eq;
        logic                  lt;
        logic                  gt;
    } vec_t;

    logic clk;
    logic rst_n;

    cmp_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    cmp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   errors;
    int   ptr;
    logic prev_eq, prev_lt, prev_gt;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: first requester at or above ptr, modulo NREQ.
    function automatic int model_grant(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_flags(input logic [NREQ*WIDTH-1:0] a,
                                               input logic [NREQ*WIDTH-1:0] b,
                                               input int g);
        int av, bv;
        av = int'(a[g*WIDTH +: WIDTH]);
        bv = int'(b[g*WIDTH +: WIDTH]);
        return {av == bv, av < bv, av > bv};
    endfunction

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_txn(input logic [NREQ-1:0] req, input logic [NREQ*WIDTH-1:0] opa,
                           input logic [NREQ*WIDTH-1:0] opb, input logic [NREQ-1:0] req_e,
                           input logic [NREQ*WIDTH-1:0] opa_e, input logic [NREQ*WIDTH-1:0] opb_e,
                           input int g, input logic [2:0] flags, input string name);
        logic [NREQ-1:0] one;
        one = NREQ'(1) << g;
        bus.req = req;
        bus.opa = opa;
        bus.opb = opb;
        @(posedge clk); #1;
        chk({name, ".eval.busy"}, 32'(bus.busy), 32'd1);
        chk({name, ".eval.gnt"}, 32'(bus.gnt_id), 32'(g));
        chk({name, ".eval.done"}, 32'(bus.done), 32'd0);
        chk({name, ".eval.hold"}, 32'({bus.eq, bus.lt, bus.gt}), 32'({prev_eq, prev_lt, prev_gt}));
        bus.req = req_e;
        bus.opa = opa_e;
        bus.opb = opb_e;
        @(posedge clk); #1;
        chk({name, ".resp.done"}, 32'(bus.done), 32'(one));
        chk({name, ".resp.flags"}, 32'({bus.eq, bus.lt, bus.gt}), 32'(flags));
        chk({name, ".resp.busy"}, 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        chk({name, ".idle.done"}, 32'(bus.done), 32'd0);
        chk({name, ".idle.busy"}, 32'(bus.busy), 32'd0);
        chk({name, ".idle.gnt"}, 32'(bus.gnt_id), 32'(g));
        chk({name, ".idle.flags"}, 32'({bus.eq, bus.lt, bus.gt}), 32'(flags));
        {prev_eq, prev_lt, prev_gt} = flags;
        ptr = (g + 1) % NREQ;
    endtask

    // Model-driven transaction with optional EVAL-time disturbance.
    task automatic model_txn(input logic [NREQ-1:0] req, input logic [NREQ*WIDTH-1:0] opa,
                             input logic [NREQ*WIDTH-1:0] opb, input logic [NREQ-1:0] req_e,
                             input logic [NREQ*WIDTH-1:0] opa_e, input logic [NREQ*WIDTH-1:0] opb_e,
                             input string name);
        int g;
        g = model_grant(req, ptr);
        run_txn(req, opa, opb, req_e, opa_e, opb_e, g, model_flags(opa, opb, g), name);
    endtask

    task automatic idle_cycle(input string name);
        bus.req = '0;
        @(posedge clk); #1;
        chk({name, ".busy"}, 32'(bus.busy), 32'd0);
        chk({name, ".done"}, 32'(bus.done), 32'd0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        bus.opa = '0;
        bus.opb = '0;
        @(posedge clk); #1;
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.flags", 32'({bus.eq, bus.lt, bus.gt}), 32'd0);
        chk("rst.gnt", 32'(bus.gnt_id), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        {prev_eq, prev_lt, prev_gt} = 3'b000;
        ptr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0]       r, re;
        logic [NREQ*WIDTH-1:0] a, b, ae, be;

        checks = 0;
        errors = 0;

        // Directed table, starting from reset (ptr = 0).
        tbl[0]  = '{4'b0001, 16'h0005, 16'h0009, 0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'b0001, 16'h0009, 16'h0009, 0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'b0001, 16'h000f, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4'b1000, 16'h7000, 16'h7000, 3, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 16'h4321, 16'h2222, 0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 16'h4321, 16'h2222, 1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{4'b1111, 16'h4321, 16'h2222, 2, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{4'b1111, 16'h4321, 16'h2222, 3, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4'b1111, 16'h4321, 16'h2222, 0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{4'b1000, 16'h0000, 16'h5000, 3, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{4'b0101, 16'h0a0b, 16'h0c03, 0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{4'b0101, 16'h0a0b, 16'h0c03, 2, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{4'b0101, 16'h0a0b, 16'h0c03, 0, 1'b0, 1'b0, 1'b1};

        rst_n   = 1'b0;
        bus.req = '0;
        bus.opa = '0;
        bus.opb = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Mid-transaction reset: requester 1 reaches EVAL, then reset.
        bus.req = 4'b0010;
        bus.opa = 16'h0050;
        bus.opb = 16'h0010;
        @(posedge clk); #1;
        chk("midrst.eval.gnt", 32'(bus.gnt_id), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.gnt", 32'(bus.gnt_id), 32'd0);
        chk("midrst.done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        chk("midrst.nodone", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        {prev_eq, prev_lt, prev_gt} = 3'b000;
        ptr = 0;
        idle_cycle("midrst.idle0");
        idle_cycle("midrst.idle1");
        run_txn(4'b0100, 16'h0300, 16'h0300, 4'b0100, 16'h0300, 16'h0300,
                2, 3'b100, "midrst.req2");

        do_reset();
        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i].req, tbl[i].opa, tbl[i].opb, tbl[i].req, tbl[i].opa, tbl[i].opb,
                    tbl[i].g, {tbl[i].eq, tbl[i].lt, tbl[i].gt}, $sformatf("tbl%0d", i));
        end

        // Operand stability: OPA[0] changes 3 -> 12 during EVAL, OPB[0] = 7.
        run_txn(4'b0001, 16'h0003, 16'h0007, 4'b0001, 16'h000c, 16'h0007,
                model_grant(4'b0001, ptr), 3'b010, "stable");
        // Withdrawal in EVAL still completes.
        model_txn(4'b0100, 16'h0900, 16'h0400, 4'b0000, 16'h0000, 16'h0000, "withdraw");

        // Exhaustive compare on requester 1.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a = '0;
                b = '0;
                a[WIDTH +: WIDTH] = WIDTH'(x);
                b[WIDTH +: WIDTH] = WIDTH'(y);
                model_txn(4'b0010, a, b, 4'b0010, a, b, $sformatf("exh_%0d_%0d", x, y));
                chk($sformatf("exh_%0d_%0d.onehot", x, y),
                    32'(bus.eq) + 32'(bus.lt) + 32'(bus.gt), 32'd1);
            end
        end

        // Randomized traffic with EVAL-time disturbance.
        for (int n = 0; n < 300; n++) begin
            r = NREQ'($urandom_range(0, 15));
            if (r == '0) begin
                idle_cycle($sformatf("rnd%0d.noreq", n));
            end else begin
                a  = (NREQ*WIDTH)'($urandom);
                b  = (NREQ*WIDTH)'($urandom);
                re = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : r;
                ae = ($urandom_range(0, 1) == 0) ? (NREQ*WIDTH)'($urandom) : a;
                be = ($urandom_range(0, 1) == 0) ? (NREQ*WIDTH)'($urandom) : b;
                model_txn(r, a, b, re, ae, be, $sformatf("rnd%0d", n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
